// File: rtl/spi_target_if.sv
// Pin-side and buffer-side signals of the SPI mode-0 responder.
// The slave modport is the responder's view; master is the initiator plus buffer.
interface spi_target_if;
    logic       SPIClk;
    logic       nSel;
    logic       SPIDi;
    logic       SPIDo;
    logic       SPIDoEn;
    logic [7:0] Status;
    logic [7:0] BufAddr;
    logic [7:0] BufWriteData;
    logic       BufWrite;
    logic       BufRead;
    logic [7:0] BufReadData;
    logic       Busy;

    modport slave (
        input  SPIClk, nSel, SPIDi, Status, BufReadData,
        output SPIDo, SPIDoEn, BufAddr, BufWriteData, BufWrite, BufRead, Busy
    );

    modport master (
        output SPIClk, nSel, SPIDi, Status, BufReadData,
        input  SPIDo, SPIDoEn, BufAddr, BufWriteData, BufWrite, BufRead, Busy
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 responder: oversamples SCK/nSel/MOSI in the FastClk domain and
// maps command/address/data framing onto a 256-byte strobe-based buffer port.
module spi_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         FastClk,
    input  logic         nReset,
    spi_target_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, IGNORE} state_t;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, nsel_sync, sdi_sync;
    logic       sclk_q, nsel_q;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift, prefetch, buf_addr, buf_wdata;
    logic       is_read, buf_write, buf_read, buf_read_q;

    // The nSel chain resets to "selected" so a still-low nSel after reset
    // produces no select edge; a high nSel just yields a harmless deselect.
    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            sclk_sync <= '0;
            nsel_sync <= '0;
            sdi_sync  <= '0;
            sclk_q    <= 1'b0;
            nsel_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SPIClk};
            nsel_sync <= {nsel_sync[SYNC_STAGES-2:0], bus.nSel};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.SPIDi};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            nsel_q    <= nsel_sync[SYNC_STAGES-1];
        end
    end

    logic sck_rise, sck_fall, select_ev, deselect_ev, byte_done, tx_boundary;
    logic [7:0] rx_byte;

    assign sck_rise    =  sclk_sync[SYNC_STAGES-1] & ~sclk_q;
    assign sck_fall    = ~sclk_sync[SYNC_STAGES-1] &  sclk_q;
    assign select_ev   = ~nsel_sync[SYNC_STAGES-1] &  nsel_q;
    assign deselect_ev =  nsel_sync[SYNC_STAGES-1] & ~nsel_q;
    assign rx_byte     = {rx_shift, sdi_sync[SYNC_STAGES-1]};
    // Deselect wins over a coincident byte completion, so no strobe escapes.
    assign byte_done   = sck_rise && (bit_cnt == 3'd7) && (state != IDLE) && !deselect_ev;
    assign tx_boundary = sck_fall && (bit_cnt == 3'd0) && (state != IDLE) && !deselect_ev;

    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        if (deselect_ev) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (select_ev) next_state = CMD;
                CMD:     if (byte_done)
                             next_state = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ADDR : IGNORE;
                ADDR:    if (byte_done) next_state = is_read ? READ : WRITE;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        bus.Busy    = (state != IDLE);
        bus.SPIDoEn = (state != IDLE);
        bus.SPIDo   = (state == CMD || state == READ) ? tx_shift[7] : 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 7'd0;
            tx_shift   <= 8'hFF;
            prefetch   <= 8'h00;
            is_read    <= 1'b0;
            buf_addr   <= 8'h00;
            buf_wdata  <= 8'h00;
            buf_write  <= 1'b0;
            buf_read   <= 1'b0;
            buf_read_q <= 1'b0;
        end else begin
            buf_write  <= 1'b0;
            buf_read   <= 1'b0;
            buf_read_q <= buf_read;
            if (buf_read_q) prefetch <= bus.BufReadData;

            if (deselect_ev || state == IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte[6:0];
            end

            if (state == IDLE && select_ev) begin
                tx_shift <= bus.Status;
            end else if (sck_fall && state != IDLE && !deselect_ev) begin
                if (bit_cnt != 3'd0)    tx_shift <= {tx_shift[6:0], 1'b1};
                else if (state == READ) tx_shift <= prefetch;
                else                    tx_shift <= 8'hFF;
            end

            if (state == CMD && byte_done) is_read <= (rx_byte == CMD_READ);
            if (state == ADDR && byte_done) begin
                buf_addr <= rx_byte;
                buf_read <= is_read;
            end
            if (state == WRITE && byte_done) begin
                buf_wdata <= rx_byte;
                buf_write <= 1'b1;
            end
            if (buf_write) buf_addr <= buf_addr + 8'd1;
            // Consume the prefetch, then fetch the following address.
            if (state == READ && tx_boundary) begin
                buf_addr <= buf_addr + 8'd1;
                buf_read <= 1'b1;
            end
        end
    end

    assign bus.BufAddr      = buf_addr;
    assign bus.BufWriteData = buf_wdata;
    assign bus.BufWrite     = buf_write;
    assign bus.BufRead      = buf_read;
endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: stimulus queues expected MISO bytes and
// write strobes, a monitor compares them as the DUT produces them.
module tb_spi_target;
    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    spi_target_if bus ();
    spi_target #(.SYNC_STAGES(SYNC)) dut (.FastClk(clk), .nReset(nReset), .bus(bus));

    logic [7:0]  mem [256];
    logic [7:0]  exp_miso[$];
    logic [7:0]  got_q[$];
    logic [15:0] exp_wr[$];
    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    always @(posedge clk) bus.BufReadData <= mem[bus.BufAddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            bus.SPIDi = tx[i];
            tick(HALF);
            bus.SPIClk = 1'b1;
            rx[i] = bus.SPIDo;
            tick(HALF);
            bus.SPIClk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
        logic [7:0] rx;
        exp_miso.push_back(exp);
        spi_bits(tx, 8, rx);
        got_q.push_back(rx);
    endtask

    task automatic select(input logic [7:0] status);
        bus.Status = status;
        bus.nSel   = 1'b0;
        tick(HALF);
    endtask

    task automatic deselect();
        tick(HALF);
        bus.nSel = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_spido"},   bus.SPIDo,        1);
        check({tag, "_spidoen"}, bus.SPIDoEn,      0);
        check({tag, "_busy"},    bus.Busy,         0);
        check({tag, "_addr"},    bus.BufAddr,      8'h00);
        check({tag, "_wdata"},   bus.BufWriteData, 8'h00);
        check({tag, "_write"},   bus.BufWrite,     0);
        check({tag, "_read"},    bus.BufRead,      0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes or a byte arrives.
    initial begin
        logic [7:0]  g, e;
        logic [15:0] w;
        forever begin
            @(negedge clk);
            if (bus.BufRead) rd_cnt++;
            if (bus.BufWrite) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check("write_expected", 32'(exp_wr.size() != 0), 1);
                end else begin
                    w = exp_wr.pop_front();
                    check("write_addr_data", {bus.BufAddr, bus.BufWriteData}, w);
                end
            end
            if (got_q.size() > 0) begin
                g = got_q.pop_front();
                if (exp_miso.size() == 0) begin
                    check("miso_expected", 32'(exp_miso.size() != 0), 1);
                end else begin
                    e = exp_miso.pop_front();
                    check("miso_byte", g, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0;
        logic [7:0] dummy;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hFF;
        nReset = 1'b0;
        bus.SPIClk = 1'b0;
        bus.nSel   = 1'b1;
        bus.SPIDi  = 1'b0;
        bus.Status = 8'h00;
        tick(3);
        check_reset_values("reset");
        nReset = 1'b1;
        tick(5);

        // Status readout, then IGNORE returns ones
        select(8'hA5);
        check("busy_selected", bus.Busy, 1);
        check("doen_selected", bus.SPIDoEn, 1);
        xfer(8'h00, 8'hA5);
        xfer(8'h00, 8'hFF);
        xfer(8'h00, 8'hFF);
        deselect();
        check("busy_after_deselect", bus.Busy, 0);

        // Write burst
        select(8'h5C);
        xfer(8'h02, 8'h5C);
        xfer(8'h10, 8'hFF);
        exp_wr.push_back(16'h1011); xfer(8'h11, 8'hFF);
        exp_wr.push_back(16'h1122); xfer(8'h22, 8'hFF);
        exp_wr.push_back(16'h1233); xfer(8'h33, 8'hFF);
        deselect();
        check("write_count", wr_cnt, 3);

        // Read burst wrapping FE -> FF -> 00
        rd0 = rd_cnt;
        select(8'h3C);
        xfer(8'h03, 8'h3C);
        xfer(8'hFE, 8'hFF);
        xfer(8'h00, 8'h01);
        xfer(8'h00, 8'h00);
        xfer(8'h00, 8'hFF);
        deselect();
        check("read_strobe_count", rd_cnt - rd0, 5);

        // Mid-byte deselect discards the partial byte
        wr0 = wr_cnt;
        select(8'h96);
        xfer(8'h02, 8'h96);
        xfer(8'h40, 8'hFF);
        spi_bits(8'hAB, 4, dummy);
        bus.nSel = 1'b1;
        tick(SYNC + 2);
        check("busy_mid_byte_deselect", bus.Busy, 0);
        tick(2 * HALF);
        check("no_write_partial", wr_cnt - wr0, 0);
        select(8'h5A);
        xfer(8'h00, 8'h5A);
        deselect();

        // Invalid command
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        select(8'hC3);
        xfer(8'h7E, 8'hC3);
        xfer(8'h02, 8'hFF);
        xfer(8'h03, 8'hFF);
        deselect();
        check("invalid_no_read", rd_cnt - rd0, 0);
        check("invalid_no_write", wr_cnt - wr0, 0);

        // Reset during the second data byte of a write burst
        select(8'h11);
        xfer(8'h02, 8'h11);
        xfer(8'h20, 8'hFF);
        exp_wr.push_back(16'h2044); xfer(8'h44, 8'hFF);
        spi_bits(8'h99, 4, dummy);
        nReset = 1'b0;
        #1;
        check_reset_values("midreset");
        tick(2);
        nReset = 1'b1;
        tick(3);
        wr0 = wr_cnt;
        spi_bits(8'h02, 8, dummy);
        spi_bits(8'h30, 8, dummy);
        spi_bits(8'h55, 8, dummy);
        tick(HALF);
        check("no_select_after_reset", bus.Busy, 0);
        check("no_write_after_reset", wr_cnt - wr0, 0);
        deselect();
        select(8'h77);
        xfer(8'h02, 8'h77);
        xfer(8'h30, 8'hFF);
        exp_wr.push_back(16'h3066); xfer(8'h66, 8'hFF);
        deselect();

        tick(20);
        check("miso_queue_drained", exp_miso.size(), 0);
        check("write_queue_drained", exp_wr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 responder that lets an external SPI initiator, such as the cartridge MCU or a bench master, read and write a 256-byte local buffer through a byte-wide strobe port. The block runs entirely in the FastClk domain. It oversamples the external SPIClk, nSel and SPIDi through synchronisers, decodes a command/address/data framing, and drives SPIDo. It sits between the external SPI pins and any block-RAM or register file that exposes a synchronous 1-cycle-latency read port.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth on SPIClk/nSel/SPIDi (≥2).

Ports:
- FastClk  in  1  system clock; all logic on posedge.
- nReset  in  1  reset, asynchronous assert, active-low.
- SPIClk  in  1  external SPI clock, idle low; max frequency FastClk/8.
- nSel  in  1  external chip select, active-low.
- SPIDi  in  1  data from initiator (MOSI).
- SPIDo  out  1  data to initiator (MISO).
- SPIDoEn  out  1  output enable for SPIDo pad, high while selected.
- Status  in  8  byte returned during the command byte.
- BufAddr  out  8  local buffer address.
- BufWriteData  out  8  write data.
- BufWrite  out  1  one-cycle write strobe.
- BufRead  out  1  one-cycle read strobe.
- BufReadData  in  8  valid the cycle after BufRead.
- Busy  out  1  high while a transaction is selected.

## Operation
- **Front end.** SPIClk, nSel and SPIDi each pass through SYNC_STAGES flops.
  - Rise and fall events are detected from the last two SPIClk samples.
  - Select and deselect events are detected from the nSel samples.
- **Mode and bit order.** Mode 0, MSB first.
  - SPIDi is sampled on an SCK rise into rx_shift[7:0].
  - 3-bit bit_cnt increments on each rise; a byte completes when bit_cnt wraps 7→0.
- **TX side.** SPIDo = tx_shift[7].
  - On select, tx_shift loads Status.
  - On an SCK fall with bit_cnt≠0, tx_shift shifts left, filling with 1.
  - On an SCK fall with bit_cnt==0 (byte boundary), tx_shift loads the next TX byte: prefetch in READ, else 0xFF.
- **States:** IDLE, CMD, ADDR, WRITE, READ, IGNORE.
  - IDLE → CMD on select.
  - CMD, byte complete: 0x02 → ADDR(write), 0x03 → ADDR(read), otherwise → IGNORE.
  - ADDR, byte complete: BufAddr ← rx byte; go to WRITE or READ. In read, BufRead pulses the following cycle.
  - WRITE, each byte complete: BufWriteData ← rx byte and BufWrite pulses the following cycle. BufAddr increments the cycle after the strobe.
  - READ: BufReadData is captured into prefetch the cycle after BufRead.
    - At each byte-boundary fall, prefetch loads into tx_shift.
    - Then BufAddr increments and BufRead pulses for the next byte.
    - MOSI content is ignored.
  - IGNORE: SPIDo = 1 until deselect.
  - Any state → IDLE on deselect.
- **Address arithmetic.** 8-bit, wraps 0xFF → 0x00.
- **Partial bytes.** Deselect mid-byte discards the partial byte: no strobe is issued and bit_cnt resets to 0.
- **Busy and output enable.** Busy = SPIDoEn = state≠IDLE.
- **Idle TX value.** SPIDo = 1 when not in READ/CMD data.

## Timing
- **Reset values:**
  - SPIDo=1, SPIDoEn=0, Busy=0
  - BufAddr=0x00, BufWriteData=0x00
  - BufWrite=0, BufRead=0
  - state=IDLE, bit_cnt=0, tx_shift=0xFF
- **Input latency.** Each external edge is visible internally SYNC_STAGES+1 FastClk cycles after the pin changes.
- **Output latency.** SPIDo changes SYNC_STAGES+1 cycles after an SCK fall. The initiator samples it half an SCK period (≥4 FastClk) later.
- **Read data timing.** BufRead is issued ≥2 cycles before the byte-boundary fall that consumes its data. With SCK ≤ FastClk/8 the prefetch is always valid at that fall.
- **Write timing.** BufWrite occurs exactly 1 cycle after the internal byte-complete event. BufAddr and BufWriteData are stable during the strobe.
- **Select and deselect.** Select and the first SCK rise are separated by ≥1 SCK half period. Deselect in the same cycle as byte-complete gives priority to deselect: no strobe.
- **Reset mid-transfer.** Reset mid-transfer returns every register to its reset value immediately. The block waits for a fresh select event, so a still-low nSel is not treated as a new select.

## Test plan
- **Status readout.** Status=0xA5, select, clock 8 bits of 0x00 → MISO=0xA5, then state IGNORE, MISO 0xFF for the following bytes.
- **Write burst.** Send 0x02, 0x10, 0x11, 0x22, 0x33 → BufWrite pulses at addresses 0x10, 0x11, 0x12 with data 0x11, 0x22, 0x33; exactly 3 strobes.
- **Read burst with wrap.** Buffer model holds mem[a]=a^0xFF. Send 0x03, 0xFE, then 3 dummy bytes → MISO returns 0x01, 0x00, 0xFF (addresses 0xFE, 0xFF, 0x00).
- **Mid-byte deselect.** Send 0x02, 0x40, 4 bits of a data byte, then deselect → no BufWrite; Busy=0 within SYNC_STAGES+2 cycles. The next transaction's Status byte is correct.
- **Invalid command.** Send 0x7E then 2 bytes → no BufRead or BufWrite; MISO 0xFF after the command byte.
- **Reset mid-transfer.** Assert nReset during the 2nd data byte of a write burst → all outputs at reset values. Strobes resume only after deselect, then select, then a new command.
